// File: rtl/ahb_decoder_mux.sv
// AHB-Lite region decoder and response mux for NSLV slaves, with a built-in
// default slave that answers unmapped transfers with a two-cycle ERROR.
//
// state  | meaning
// D_IDLE | default slave not owning a data phase
// D_ERR1 | first ERROR cycle: hready=0, hresp=1
// D_ERR2 | second ERROR cycle: hready=1, hresp=1
module ahb_decoder_mux #(
  parameter int NSLV    = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int RGN_LSB = 28,
  parameter int RGN_W   = 3
) (
  input  logic             hclk,
  input  logic             hresetn,
  input  logic [AW-1:0]    haddr,
  input  logic [1:0]       htrans,
  output logic [NSLV-1:0]  hsel,
  input  logic [NSLV*DW-1:0] hrdata_s,
  input  logic [NSLV-1:0]  hreadyout_s,
  input  logic [NSLV-1:0]  hresp_s,
  output logic [DW-1:0]    hrdata,
  output logic             hready,
  output logic             hresp,
  output logic [7:0]       err_cnt
);

  localparam int DSW = $clog2(NSLV + 2);
  localparam logic [DSW-1:0] DSEL_DEF  = DSW'(NSLV);
  localparam logic [DSW-1:0] DSEL_NONE = DSW'(NSLV + 1);

  typedef enum logic [1:0] {D_IDLE, D_ERR1, D_ERR2} dstate_e;

  logic [RGN_W-1:0] rgn;
  logic             mapped;
  logic             hsel_def;
  logic             acc_def;
  logic [DSW-1:0]   dsel_d, dsel_q;
  dstate_e          dstate_d, dstate_q;
  logic [7:0]       err_cnt_d, err_cnt_q;
  logic             unused_inputs;

  assign rgn      = haddr[RGN_LSB +: RGN_W];
  assign mapped   = ({1'b0, rgn} < (RGN_W+1)'(NSLV));
  assign hsel_def = ~mapped;
  assign unused_inputs = ^{haddr, htrans[0]};

  always_comb begin
    hsel = '0;
    for (int i = 0; i < NSLV; i++) begin
      hsel[i] = ({1'b0, rgn} == (RGN_W+1)'(i));
    end
  end

  // Owner of the data phase; only advances when the bus accepts an address.
  always_comb begin
    dsel_d = dsel_q;
    if (hready) begin
      if (htrans[1]) begin
        dsel_d = mapped ? DSW'(rgn) : DSEL_DEF;
      end else begin
        dsel_d = DSEL_NONE;
      end
    end
  end

  always_comb begin
    hrdata = '0;
    hready = 1'b1;
    hresp  = 1'b0;
    if (dsel_q == DSEL_DEF) begin
      hready = (dstate_q != D_ERR1);
      hresp  = (dstate_q != D_IDLE);
    end
    for (int i = 0; i < NSLV; i++) begin
      if (dsel_q == DSW'(i)) begin
        hrdata = hrdata_s[i*DW +: DW];
        hready = hreadyout_s[i];
        hresp  = hresp_s[i];
      end
    end
  end

  assign acc_def = hready & hsel_def & htrans[1];

  always_comb begin
    dstate_d = dstate_q;
    case (dstate_q)
      D_IDLE:  if (acc_def) dstate_d = D_ERR1;
      D_ERR1:  dstate_d = D_ERR2;
      D_ERR2:  dstate_d = acc_def ? D_ERR1 : D_IDLE;
      default: dstate_d = D_IDLE;
    endcase
  end

  // One count per ERROR response, taken as ERR1 hands over to ERR2.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (dstate_q == D_ERR1 && err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dsel_q    <= DSEL_NONE;
      dstate_q  <= D_IDLE;
      err_cnt_q <= '0;
    end else begin
      dsel_q    <= dsel_d;
      dstate_q  <= dstate_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;

endmodule
